// File: rtl/cp0_exception_commit_if.sv
// Commit-side bus of cp0_exception_commit: exception/ERET commit, MTC0/MFC0 access,
// interrupt lines, CP0 state outputs and the pipeline redirect.
interface cp0_exception_commit_if;
    logic        exception_valid;
    logic [4:0]  exc_code;
    logic [31:0] exc_pc;
    logic        exc_in_delay_slot;
    logic        exc_vaddr_valid;
    logic [31:0] exc_vaddr;
    logic        exc_tlb_refill;
    logic        eret;
    logic        cp0_wen;
    logic [4:0]  cp0_waddr;
    logic [31:0] cp0_wdata;
    logic [4:0]  cp0_raddr;
    logic [31:0] cp0_rdata;
    logic [5:0]  ext_int;
    logic [31:0] cp0_status;
    logic [31:0] cp0_cause;
    logic        timer_interrupt;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    // Pipeline / exception_checker side
    modport master (
        output exception_valid, exc_code, exc_pc, exc_in_delay_slot, exc_vaddr_valid,
               exc_vaddr, exc_tlb_refill, eret, cp0_wen, cp0_waddr, cp0_wdata,
               cp0_raddr, ext_int,
        input  cp0_rdata, cp0_status, cp0_cause, timer_interrupt, redirect_valid, redirect_pc
    );

    // CP0 side
    modport slave (
        input  exception_valid, exc_code, exc_pc, exc_in_delay_slot, exc_vaddr_valid,
               exc_vaddr, exc_tlb_refill, eret, cp0_wen, cp0_waddr, cp0_wdata,
               cp0_raddr, ext_int,
        output cp0_rdata, cp0_status, cp0_cause, timer_interrupt, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/cp0_exception_commit.sv
// CP0 exception/ERET commit: owns Status/Cause/EPC/BadVAddr/Count/Compare, issues a one-cycle redirect.
// Optional feature macro CP0_TLB_EXC_EN adds EntryHi (reg 10) and TLB-refill vectoring.
module cp0_exception_commit #(
    parameter logic [31:0] EXC_VEC_BOOT = 32'hBFC0_0200,
    parameter logic [31:0] EXC_VEC_NORM = 32'h8000_0000,
    parameter logic [31:0] GEN_OFFSET   = 32'h0000_0180
) (
    input logic               clk,
    input logic               reset,
    cp0_exception_commit_if.slave bus
);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic        take_exc_s;
    logic        take_eret_s;
    logic        take_wr_s;
    logic        refill_s;

    logic        bev_r;
    logic [7:0]  im_r;
    logic        exl_r;
    logic        ie_r;
    logic        bd_r;
    logic        ti_r;
    logic [5:0]  ip_hw_r;
    logic [1:0]  ip_sw_r;
    logic [4:0]  exc_code_r;
    logic [31:0] epc_r;
    logic [31:0] badvaddr_r;
    logic [31:0] count_r;
    logic [31:0] compare_r;
    logic        tick_r;
    logic        redirect_valid_r;
    logic [31:0] redirect_pc_r;

    logic [31:0] count_inc_s;
    logic        wr_status_s;
    logic        wr_cause_s;
    logic        wr_epc_s;
    logic        wr_count_s;
    logic        wr_compare_s;
    logic [31:0] status_s;
    logic [31:0] cause_s;
    logic [31:0] rdata_s;

`ifdef CP0_TLB_EXC_EN
    logic [18:0] vpn2_r;
    logic [7:0]  asid_r;
    logic        wr_entryhi_s;
    logic        tlb_exc_s;
`endif

    function automatic logic [31:0] exc_target(input logic bev, input logic exl, input logic refill);
        logic [31:0] base;
        base = bev ? EXC_VEC_BOOT : EXC_VEC_NORM;
        if (refill && !exl) begin
            exc_target = base;
        end else begin
            exc_target = base + GEN_OFFSET;
        end
    endfunction

`ifdef CP0_TLB_EXC_EN
    assign refill_s     = bus.exc_tlb_refill;
    assign wr_entryhi_s = take_wr_s && (bus.cp0_waddr == 5'd10);
    assign tlb_exc_s    = bus.exc_tlb_refill || (bus.exc_code == 5'd1) ||
                          (bus.exc_code == 5'd2) || (bus.exc_code == 5'd3);
`else
    // Refill vectoring disabled: the input is deliberately masked off.
    assign refill_s = bus.exc_tlb_refill & 1'b0;
`endif

    assign count_inc_s  = count_r + 32'd1;
    assign wr_status_s  = take_wr_s && (bus.cp0_waddr == 5'd12);
    assign wr_cause_s   = take_wr_s && (bus.cp0_waddr == 5'd13);
    assign wr_epc_s     = take_wr_s && (bus.cp0_waddr == 5'd14);
    assign wr_count_s   = take_wr_s && (bus.cp0_waddr == 5'd9);
    assign wr_compare_s = take_wr_s && (bus.cp0_waddr == 5'd11);

    assign status_s = {9'd0, bev_r, 6'd0, im_r, 6'd0, exl_r, ie_r};
    assign cause_s  = {bd_r, ti_r, 14'd0, ip_hw_r[5] | ti_r, ip_hw_r[4:0], ip_sw_r,
                       1'b0, exc_code_r, 2'd0};

    // State register for the RUN/DRAIN flush sequencer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next state and commit arbitration; DRAIN swallows the wrong-path cycle
    always_comb begin
        state_next_s = state_r;
        take_exc_s   = 1'b0;
        take_eret_s  = 1'b0;
        take_wr_s    = 1'b0;
        case (state_r)
            ST_RUN: begin
                if (bus.exception_valid) begin
                    take_exc_s   = 1'b1;
                    state_next_s = ST_DRAIN;
                end else if (bus.eret) begin
                    take_eret_s  = 1'b1;
                    state_next_s = ST_DRAIN;
                end else begin
                    take_wr_s    = bus.cp0_wen;
                    state_next_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                state_next_s = ST_RUN;
            end
            default: begin
                state_next_s = ST_RUN;
            end
        endcase
    end

    // Redirect pulse and target, computed from pre-update EXL/BEV/EPC
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            redirect_valid_r <= 1'b0;
            redirect_pc_r    <= 32'd0;
        end else begin
            redirect_valid_r <= take_exc_s || take_eret_s;
            if (take_exc_s) begin
                redirect_pc_r <= exc_target(bev_r, exl_r, refill_s);
            end else if (take_eret_s) begin
                redirect_pc_r <= epc_r;
            end else begin
                redirect_pc_r <= redirect_pc_r;
            end
        end
    end

    // Status / Cause / EPC / BadVAddr updates
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bev_r      <= 1'b1;
            im_r       <= 8'd0;
            exl_r      <= 1'b0;
            ie_r       <= 1'b0;
            bd_r       <= 1'b0;
            ip_hw_r    <= 6'd0;
            ip_sw_r    <= 2'd0;
            exc_code_r <= 5'd0;
            epc_r      <= 32'd0;
            badvaddr_r <= 32'd0;
        end else begin
            ip_hw_r <= bus.ext_int;
            if (take_exc_s) begin
                // A nested exception keeps the original EPC/BD so ERET returns to the outer fault
                if (!exl_r) begin
                    epc_r <= bus.exc_in_delay_slot ? (bus.exc_pc - 32'd4) : bus.exc_pc;
                    bd_r  <= bus.exc_in_delay_slot;
                end
                exc_code_r <= bus.exc_code;
                exl_r      <= 1'b1;
                if (bus.exc_vaddr_valid) begin
                    badvaddr_r <= bus.exc_vaddr;
                end
            end else if (take_eret_s) begin
                exl_r <= 1'b0;
            end else begin
                if (wr_status_s) begin
                    bev_r <= bus.cp0_wdata[22];
                    im_r  <= bus.cp0_wdata[15:8];
                    exl_r <= bus.cp0_wdata[1];
                    ie_r  <= bus.cp0_wdata[0];
                end
                if (wr_cause_s) begin
                    ip_sw_r <= bus.cp0_wdata[9:8];
                end
                if (wr_epc_s) begin
                    epc_r <= bus.cp0_wdata;
                end
            end
        end
    end

    // Count/Compare timer; a Compare write always wins over a same-cycle match
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_r    <= 1'b0;
            count_r   <= 32'd0;
            compare_r <= 32'd0;
            ti_r      <= 1'b0;
        end else begin
            tick_r <= ~tick_r;
            if (wr_count_s) begin
                count_r <= bus.cp0_wdata;
            end else if (tick_r) begin
                count_r <= count_inc_s;
            end
            if (wr_compare_s) begin
                compare_r <= bus.cp0_wdata;
                ti_r      <= 1'b0;
            end else if (tick_r && !wr_count_s && (count_inc_s == compare_r)) begin
                ti_r <= 1'b1;
            end
        end
    end

`ifdef CP0_TLB_EXC_EN
    // EntryHi: VPN2 captured by TLB exceptions, ASID software-written
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vpn2_r <= 19'd0;
            asid_r <= 8'd0;
        end else begin
            if (take_exc_s && tlb_exc_s) begin
                vpn2_r <= bus.exc_vaddr[31:13];
            end
            if (wr_entryhi_s) begin
                asid_r <= bus.cp0_wdata[7:0];
            end
        end
    end
`endif

    // MFC0 read mux; sees register state before any same-cycle write
    always_comb begin
        rdata_s = 32'd0;
        case (bus.cp0_raddr)
            5'd8:    rdata_s = badvaddr_r;
            5'd9:    rdata_s = count_r;
`ifdef CP0_TLB_EXC_EN
            5'd10:   rdata_s = {vpn2_r, 5'd0, asid_r};
`endif
            5'd11:   rdata_s = compare_r;
            5'd12:   rdata_s = status_s;
            5'd13:   rdata_s = cause_s;
            5'd14:   rdata_s = epc_r;
            default: rdata_s = 32'd0;
        endcase
    end

    assign bus.cp0_rdata       = rdata_s;
    assign bus.cp0_status      = status_s;
    assign bus.cp0_cause       = cause_s;
    assign bus.timer_interrupt = ti_r;
    assign bus.redirect_valid  = redirect_valid_r;
    assign bus.redirect_pc     = redirect_pc_r;

endmodule

// File: tb/tb_cp0_exception_commit.sv
// Bench for cp0_exception_commit: directed vector table, mid-flush reset, then random
// traffic against a register-level reference model.
module tb_cp0_exception_commit;

    localparam bit TLB_EN =
`ifdef CP0_TLB_EXC_EN
        1'b1;
`else
        1'b0;
`endif
    localparam logic [31:0] REFILL_RPC  = TLB_EN ? 32'h8000_0000 : 32'h8000_0180;
    localparam logic [31:0] ENTRYHI_EXP = TLB_EN ? 32'h1234_6000 : 32'h0000_0000;
    localparam logic [31:0] STATUS_MASK = 32'h0040_FF03;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cp0_exception_commit_if bus ();
    cp0_exception_commit dut (.clk(clk), .reset(reset), .bus(bus));

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        exc;
        logic [4:0]  code;
        logic [31:0] pc;
        logic        ds;
        logic        vv;
        logic [31:0] vaddr;
        logic        refill;
        logic        eret;
        logic        wen;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        exp_rv;
        logic [31:0] exp_rpc;
        logic [4:0]  raddr;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t tbl[$];

    // reference model state, kept as architectural words
    logic [31:0] m_status, m_cause, m_epc, m_bad, m_count, m_compare, m_rpc, m_entryhi;
    logic [5:0]  m_ip_hw;
    logic        m_ti, m_tick, m_drain, m_rv;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic vec_t v(input logic exc, input logic [4:0] code, input logic [31:0] pc,
                               input logic ds, input logic vv, input logic [31:0] vaddr,
                               input logic refill, input logic eret, input logic wen,
                               input logic [4:0] waddr, input logic [31:0] wdata,
                               input logic exp_rv, input logic [31:0] exp_rpc,
                               input logic [4:0] raddr, input logic [31:0] exp_rdata);
        vec_t r;
        r.exc = exc; r.code = code; r.pc = pc; r.ds = ds; r.vv = vv; r.vaddr = vaddr;
        r.refill = refill; r.eret = eret; r.wen = wen; r.waddr = waddr; r.wdata = wdata;
        r.exp_rv = exp_rv; r.exp_rpc = exp_rpc; r.raddr = raddr; r.exp_rdata = exp_rdata;
        return r;
    endfunction

    function automatic vec_t vi(input logic [4:0] raddr, input logic [31:0] exp);
        return v(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0,
                 1'b0, 32'd0, raddr, exp);
    endfunction

    function automatic vec_t vw(input logic [4:0] waddr, input logic [31:0] wdata,
                                input logic [4:0] raddr, input logic [31:0] exp);
        return v(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, waddr, wdata,
                 1'b0, 32'd0, raddr, exp);
    endfunction

    task automatic drive_idle();
        bus.exception_valid = 1'b0; bus.exc_code = 5'd0; bus.exc_pc = 32'd0;
        bus.exc_in_delay_slot = 1'b0; bus.exc_vaddr_valid = 1'b0; bus.exc_vaddr = 32'd0;
        bus.exc_tlb_refill = 1'b0; bus.eret = 1'b0; bus.cp0_wen = 1'b0;
        bus.cp0_waddr = 5'd0; bus.cp0_wdata = 32'd0; bus.ext_int = 6'd0;
    endtask

    task automatic m_reset();
        m_status = 32'h0040_0000; m_cause = 32'd0; m_epc = 32'd0; m_bad = 32'd0;
        m_count = 32'd0; m_compare = 32'd0; m_rpc = 32'd0; m_entryhi = 32'd0;
        m_ip_hw = 6'd0; m_ti = 1'b0; m_tick = 1'b0; m_drain = 1'b0; m_rv = 1'b0;
    endtask

    function automatic logic [31:0] m_cause_word();
        logic [31:0] c;
        c = m_cause;
        c[30] = m_ti;
        c[15:10] = {m_ip_hw[5] | m_ti, m_ip_hw[4:0]};
        return c;
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd8:    return m_bad;
            5'd9:    return m_count;
            5'd10:   return TLB_EN ? m_entryhi : 32'd0;
            5'd11:   return m_compare;
            5'd12:   return m_status;
            5'd13:   return m_cause_word();
            5'd14:   return m_epc;
            default: return 32'd0;
        endcase
    endfunction

    // advance the model by one clock using the inputs currently on the bus
    task automatic m_step();
        logic inc, a_exc, a_eret, a_wr, bev, exl, refill, cmp_wr, cnt_wr;
        logic [31:0] old_compare, wd;
        inc = m_tick;
        m_tick = !m_tick;
        a_exc  = !m_drain && bus.exception_valid;
        a_eret = !m_drain && !bus.exception_valid && bus.eret;
        a_wr   = !m_drain && !bus.exception_valid && !bus.eret && bus.cp0_wen;
        m_drain = a_exc || a_eret;
        m_rv = m_drain;
        bev = m_status[22];
        exl = m_status[1];
        refill = TLB_EN && bus.exc_tlb_refill;
        wd = bus.cp0_wdata;
        cmp_wr = a_wr && (bus.cp0_waddr == 5'd11);
        cnt_wr = a_wr && (bus.cp0_waddr == 5'd9);
        old_compare = m_compare;
        if (cnt_wr) m_count = wd;
        else if (inc) begin
            m_count = m_count + 32'd1;
            if (m_count == old_compare && !cmp_wr) m_ti = 1'b1;
        end
        if (cmp_wr) begin
            m_compare = wd;
            m_ti = 1'b0;
        end
        if (a_exc) begin
            m_rpc = (bev ? 32'hBFC0_0200 : 32'h8000_0000) + ((refill && !exl) ? 32'd0 : 32'h180);
            if (!exl) begin
                m_epc = bus.exc_in_delay_slot ? bus.exc_pc - 32'd4 : bus.exc_pc;
                m_cause[31] = bus.exc_in_delay_slot;
            end
            m_cause[6:2] = bus.exc_code;
            m_status[1] = 1'b1;
            if (bus.exc_vaddr_valid) m_bad = bus.exc_vaddr;
            if (TLB_EN && (refill || bus.exc_code == 5'd1 || bus.exc_code == 5'd2 ||
                           bus.exc_code == 5'd3))
                m_entryhi = {bus.exc_vaddr[31:13], m_entryhi[12:0]};
        end else if (a_eret) begin
            m_rpc = m_epc;
            m_status[1] = 1'b0;
        end else if (a_wr) begin
            case (bus.cp0_waddr)
                5'd10:   if (TLB_EN) m_entryhi[7:0] = wd[7:0];
                5'd12:   m_status = (m_status & ~STATUS_MASK) | (wd & STATUS_MASK);
                5'd13:   m_cause[9:8] = wd[9:8];
                5'd14:   m_epc = wd;
                default: ;
            endcase
        end
        m_ip_hw = bus.ext_int;
    endtask

    initial begin
        // exc, code, pc, ds, vv, vaddr, refill, eret, wen, waddr, wdata, rv, rpc, raddr, rdata
        tbl.push_back(vi(5'd12, 32'h0040_0000));
        tbl.push_back(vi(5'd9, 32'd1));
        tbl.push_back(vi(5'd9, 32'd1));
        tbl.push_back(vi(5'd9, 32'd2));
        tbl.push_back(v(1'b1, 5'd4, 32'h8000_1004, 1'b1, 1'b1, 32'h1003, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0,
                        1'b1, 32'hBFC0_0380, 5'd14, 32'h8000_1000));
        tbl.push_back(vi(5'd8, 32'h0000_1003));
        tbl.push_back(vi(5'd12, 32'h0040_0002));
        tbl.push_back(vi(5'd13, 32'h8000_0010));
        tbl.push_back(v(1'b1, 5'd8, 32'h8000_2000, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0,
                        1'b1, 32'hBFC0_0380, 5'd14, 32'h8000_1000));
        tbl.push_back(v(1'b1, 5'd12, 32'h0000_1234, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0,
                        1'b0, 32'd0, 5'd13, 32'h8000_0020));
        tbl.push_back(vw(5'd12, 32'h0000_0003, 5'd12, 32'h0000_0003));
        tbl.push_back(vw(5'd14, 32'h8000_0040, 5'd14, 32'h8000_0040));
        tbl.push_back(v(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 5'd14, 32'hDEAD_BEEF,
                        1'b1, 32'h8000_0040, 5'd14, 32'h8000_0040));
        tbl.push_back(vi(5'd12, 32'h0000_0001));
        tbl.push_back(v(1'b1, 5'd4, 32'h8000_3000, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0,
                        1'b1, 32'h8000_0180, 5'd14, 32'h8000_3000));
        tbl.push_back(v(1'b1, 5'd2, 32'h8000_3100, 1'b0, 1'b1, 32'h5555_0000, 1'b1, 1'b0, 1'b0, 5'd0,
                        32'd0, 1'b0, 32'd0, 5'd12, 32'h0000_0003));
        tbl.push_back(vw(5'd12, 32'h0000_0000, 5'd12, 32'h0000_0000));
        tbl.push_back(v(1'b1, 5'd2, 32'h8000_4000, 1'b0, 1'b1, 32'h1234_6000, 1'b1, 1'b0, 1'b0, 5'd0,
                        32'd0, 1'b1, REFILL_RPC, 5'd8, 32'h1234_6000));
        tbl.push_back(vi(5'd10, ENTRYHI_EXP));
        tbl.push_back(vw(5'd11, 32'd10, 5'd11, 32'd10));
        tbl.push_back(vw(5'd9, 32'd8, 5'd9, 32'd8));
        tbl.push_back(vi(5'd9, 32'd9));
        tbl.push_back(vi(5'd13, 32'h0000_0008));
        tbl.push_back(vi(5'd13, 32'h4000_8008));
        tbl.push_back(vi(5'd9, 32'd10));
        tbl.push_back(vw(5'd11, 32'd100, 5'd13, 32'h0000_0008));
        tbl.push_back(vw(5'd13, 32'hFFFF_FFFF, 5'd13, 32'h0000_0308));
        tbl.push_back(vw(5'd8, 32'h0000_0000, 5'd8, 32'h1234_6000));
        tbl.push_back(vw(5'd3, 32'hFFFF_FFFF, 5'd3, 32'h0000_0000));

        drive_idle();
        bus.cp0_raddr = 5'd0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // directed vectors: one clock per row
        for (int i = 0; i < tbl.size(); i++) begin
            bus.exception_valid = tbl[i].exc; bus.exc_code = tbl[i].code; bus.exc_pc = tbl[i].pc;
            bus.exc_in_delay_slot = tbl[i].ds; bus.exc_vaddr_valid = tbl[i].vv;
            bus.exc_vaddr = tbl[i].vaddr; bus.exc_tlb_refill = tbl[i].refill; bus.eret = tbl[i].eret;
            bus.cp0_wen = tbl[i].wen; bus.cp0_waddr = tbl[i].waddr; bus.cp0_wdata = tbl[i].wdata;
            @(posedge clk);
            #1;
            drive_idle();
            bus.cp0_raddr = tbl[i].raddr;
            #1;
            check32($sformatf("vec%0d_redirect_valid", i), {31'd0, bus.redirect_valid}, {31'd0, tbl[i].exp_rv});
            if (tbl[i].exp_rv) check32($sformatf("vec%0d_redirect_pc", i), bus.redirect_pc, tbl[i].exp_rpc);
            check32($sformatf("vec%0d_rdata_r%0d", i, tbl[i].raddr), bus.cp0_rdata, tbl[i].exp_rdata);
            if (tbl[i].raddr == 5'd13)
                check32($sformatf("vec%0d_timer_interrupt", i), {31'd0, bus.timer_interrupt},
                        {31'd0, tbl[i].exp_rdata[30]});
        end

        // reset asserted during the DRAIN cycle
        bus.exception_valid = 1'b1; bus.exc_code = 5'd5; bus.exc_pc = 32'h8000_5000;
        bus.exc_vaddr_valid = 1'b1; bus.exc_vaddr = 32'h0000_0ABC;
        @(posedge clk);
        #1;
        drive_idle();
        check32("drain_redirect_valid", {31'd0, bus.redirect_valid}, 32'd1);
        reset = 1'b1;
        #1;
        check32("rst_redirect_valid", {31'd0, bus.redirect_valid}, 32'd0);
        check32("rst_redirect_pc", bus.redirect_pc, 32'd0);
        check32("rst_status", bus.cp0_status, 32'h0040_0000);
        check32("rst_cause", bus.cp0_cause, 32'd0);
        check32("rst_timer_interrupt", {31'd0, bus.timer_interrupt}, 32'd0);
        for (int a = 8; a <= 14; a++) begin
            bus.cp0_raddr = a[4:0];
            #1;
            check32($sformatf("rst_rdata_r%0d", a), bus.cp0_rdata, (a == 12) ? 32'h0040_0000 : 32'd0);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        m_reset();

        // random traffic against the model; the first cycles walk Count over its wrap
        for (int c = 0; c < 600; c++) begin
            logic [4:0] wsel[9];
            wsel = '{5'd8, 5'd9, 5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd3, 5'd15};
            drive_idle();
            if (c == 0) begin
                bus.cp0_wen = 1'b1; bus.cp0_waddr = 5'd9; bus.cp0_wdata = 32'hFFFF_FFFE;
                bus.cp0_raddr = 5'd9;
            end else if (c < 4) begin
                bus.cp0_raddr = 5'd9;
            end else begin
                bus.exception_valid = ($urandom % 8) == 0;
                bus.exc_code = 5'($urandom);
                bus.exc_pc = $urandom;
                bus.exc_in_delay_slot = 1'($urandom);
                bus.exc_vaddr_valid = 1'($urandom);
                bus.exc_vaddr = $urandom;
                bus.exc_tlb_refill = ($urandom % 4) == 0;
                bus.eret = ($urandom % 6) == 0;
                bus.cp0_wen = 1'($urandom);
                bus.cp0_waddr = wsel[$urandom_range(0, 8)];
                bus.cp0_wdata = (bus.cp0_waddr == 5'd11) ? m_count + 32'($urandom_range(0, 4)) : $urandom;
                bus.cp0_raddr = wsel[$urandom_range(0, 8)];
                bus.ext_int = 6'($urandom);
            end
            m_step();
            @(posedge clk);
            #1;
            check32($sformatf("rnd%0d_redirect_valid", c), {31'd0, bus.redirect_valid}, {31'd0, m_rv});
            check32($sformatf("rnd%0d_redirect_pc", c), bus.redirect_pc, m_rpc);
            check32($sformatf("rnd%0d_status", c), bus.cp0_status, m_status);
            check32($sformatf("rnd%0d_cause", c), bus.cp0_cause, m_cause_word());
            check32($sformatf("rnd%0d_timer_interrupt", c), {31'd0, bus.timer_interrupt}, {31'd0, m_ti});
            check32($sformatf("rnd%0d_rdata_r%0d", c, bus.cp0_raddr), bus.cp0_rdata, m_read(bus.cp0_raddr));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
